// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, BTB entry layout
// and the counter saturation helper.
package bp_pkg;

    localparam int BP_XLEN    = 32;
    // Tags are stored zero-extended to the widest tag any legal ENTRIES (>=2) can need.
    localparam int BP_TAG_MAX = BP_XLEN - 3;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t CTR_RESET = WNT;
    localparam bp_ctr_t CTR_ALLOC = WT;

    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        logic [BP_XLEN-1:0]    target;
        bp_ctr_t               ctr;
    } btb_entry_t;

    function automatic bp_ctr_t ctrNext(input bp_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : bp_ctr_t'(ctr + 2'd1);
        end
        return (ctr == SNT) ? SNT : bp_ctr_t'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bus between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if #(
    parameter int XLEN = 32
);

    logic [XLEN-1:0] PCF;
    logic            PredTakenF;
    logic [XLEN-1:0] PredNextPCF;
    logic            ValidE;
    logic            BranchE;
    logic            JumpE;
    logic            PCSrcE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] PCTargetE;
    logic [XLEN-1:0] PredNextPCE;
    logic            MispredictE;
    logic [XLEN-1:0] RedirectPCE;
    logic [31:0]     BrCount;
    logic [31:0]     MissCount;

    modport master (
        output PCF, ValidE, BranchE, JumpE, PCSrcE, PCE, PCPlus4E, PCTargetE, PredNextPCE,
        input  PredTakenF, PredNextPCF, MispredictE, RedirectPCE, BrCount, MissCount
    );

    modport slave (
        input  PCF, ValidE, BranchE, JumpE, PCSrcE, PCE, PCPlus4E, PCTargetE, PredNextPCE,
        output PredTakenF, PredNextPCF, MispredictE, RedirectPCE, BrCount, MissCount
    );

endinterface

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB/BHT storage: combinational fetch and execute read ports, one
// synchronous write port at the execute index, synchronous clear on reset.
module btb_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] idxF,
    output btb_entry_t      entryF,
    input  logic [IDXW-1:0] idxE,
    output btb_entry_t      entryE,
    input  logic            wrEn,
    input  btb_entry_t      wrEntry
);

    btb_entry_t entries [ENTRIES];

    // Reads see the array before this cycle's write lands.
    assign entryF = entries[idxF];
    assign entryE = entries[idxE];

    // NOTE: only valid and ctr are cleared; tag/target are don't-care while invalid,
    // so they stay plain storage without a reset path.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                // NOTE: non-blocking so every read this cycle sees pre-edge state.
                entries[i].valid <= 1'b0;
                entries[i].ctr   <= CTR_RESET;
            end
        end else if (wrEn) begin
            entries[idxE] <= wrEntry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB lookup in F, training and mispredict/redirect in E.
// Optional macro PERF_CNT_EN enables the branch and mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = BP_XLEN  // entry struct width comes from bp_pkg
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bus
);

    localparam int IDXW = $clog2(ENTRIES);

    logic [IDXW-1:0]       idxF;
    logic [IDXW-1:0]       idxE;
    logic [BP_TAG_MAX-1:0] tagF;
    logic [BP_TAG_MAX-1:0] tagE;
    btb_entry_t            entryF;
    btb_entry_t            entryE;
    btb_entry_t            wrEntry;
    logic                  wrEn;
    logic                  hitF;
    logic                  hitE;
    logic                  predTakenF;
    logic [XLEN-1:0]       redirectPC;
    logic                  mispredict;
    logic                  unusedBits;

    assign idxF = bus.PCF[IDXW+1:2];
    assign idxE = bus.PCE[IDXW+1:2];
    assign tagF = BP_TAG_MAX'(bus.PCF[XLEN-1:IDXW+2]);
    assign tagE = BP_TAG_MAX'(bus.PCE[XLEN-1:IDXW+2]);
    assign unusedBits = ^{bus.PCF[1:0], bus.PCE[1:0]};

    btb_table #(
        .ENTRIES (ENTRIES),
        .IDXW    (IDXW)
    ) u_btb (
        .clk     (clk),
        .reset   (reset),
        .idxF    (idxF),
        .entryF  (entryF),
        .idxE    (idxE),
        .entryE  (entryE),
        .wrEn    (wrEn),
        .wrEntry (wrEntry)
    );

    assign hitF       = entryF.valid && (entryF.tag == tagF);
    assign predTakenF = hitF && entryF.ctr[1];
    assign bus.PredTakenF  = predTakenF;
    assign bus.PredNextPCF = predTakenF ? entryF.target : bus.PCF + XLEN'(4);

    // A single address compare catches wrong direction, wrong target and stale entries.
    assign redirectPC      = bus.PCSrcE ? bus.PCTargetE : bus.PCPlus4E;
    assign mispredict      = bus.ValidE && (redirectPC != bus.PredNextPCE);
    assign bus.RedirectPCE = redirectPC;
    assign bus.MispredictE = mispredict;

    assign hitE = entryE.valid && (entryE.tag == tagE);

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        wrEn    = 1'b0;
        wrEntry = entryE;
        if (bus.ValidE) begin
            if (bus.JumpE) begin
                wrEn    = 1'b1;
                wrEntry = '{valid: 1'b1, tag: tagE, target: bus.PCTargetE, ctr: ST};
            end else if (bus.BranchE) begin
                if (hitE) begin
                    wrEn        = 1'b1;
                    wrEntry.ctr = ctrNext(entryE.ctr, bus.PCSrcE);
                    if (bus.PCSrcE) begin
                        wrEntry.target = bus.PCTargetE;
                    end
                end else if (bus.PCSrcE) begin
                    wrEn    = 1'b1;
                    wrEntry = '{valid: 1'b1, tag: tagE, target: bus.PCTargetE, ctr: CTR_ALLOC};
                end
            end else if (hitE) begin
                wrEn          = 1'b1;
                wrEntry.valid = 1'b0;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] brCount;
    logic [31:0] missCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            brCount   <= '0;
            missCount <= '0;
        end else begin
            if (bus.ValidE && (bus.BranchE || bus.JumpE)) begin
                brCount <= brCount + 32'd1;
            end
            if (mispredict) begin
                missCount <= missCount + 32'd1;
            end
        end
    end

    assign bus.BrCount   = brCount;
    assign bus.MissCount = missCount;
`else
    assign bus.BrCount   = '0;
    assign bus.MissCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=64): expectations are queued as
// stimulus is driven and compared against the DUT outputs on the following negedge.
module tb_branch_predictor;

    typedef enum {K_PTF, K_PNF, K_MIS, K_RED, K_BR, K_MISS} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bus ();

    branch_predictor #(
        .ENTRIES (64),
        .XLEN    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_PTF:   return {31'd0, bus.PredTakenF};
            K_PNF:   return bus.PredNextPCF;
            K_MIS:   return {31'd0, bus.MispredictE};
            K_RED:   return bus.RedirectPCE;
            K_BR:    return bus.BrCount;
            default: return bus.MissCount;
        endcase
    endfunction

    function automatic logic [31:0] perf(input int v);
`ifdef PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    task automatic expectOut(input string tag, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic expectFetch(input string tag, input logic taken, input logic [31:0] nextPc);
        expectOut({tag, "_taken"}, K_PTF, {31'd0, taken});
        expectOut({tag, "_next"}, K_PNF, nextPc);
    endtask

    task automatic expectE(input string tag, input logic mis, input logic [31:0] redirect);
        expectOut({tag, "_mis"}, K_MIS, {31'd0, mis});
        expectOut({tag, "_redirect"}, K_RED, redirect);
    endtask

    task automatic expectCnt(input string tag, input int br, input int miss);
        expectOut({tag, "_br"}, K_BR, perf(br));
        expectOut({tag, "_miss"}, K_MISS, perf(miss));
    endtask

    task automatic setE(input logic v, input logic br, input logic jmp, input logic taken,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pred);
        bus.ValidE      = v;
        bus.BranchE     = br;
        bus.JumpE       = jmp;
        bus.PCSrcE      = taken;
        bus.PCE         = pc;
        bus.PCPlus4E    = pc + 32'd4;
        bus.PCTargetE   = tgt;
        bus.PredNextPCE = pred;
    endtask

    task automatic idleE();
        setE(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Compare everything queued for this cycle, then advance past the next edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    logic       outs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       miss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] pc;

    initial begin
        reset   = 1'b1;
        bus.PCF = 32'h100;
        idleE();
        @(posedge clk);
        #1;

        // Reset state
        expectFetch("reset", 1'b0, 32'h104);
        expectOut("reset_mis", K_MIS, 32'd0);
        expectCnt("reset", 0, 0);
        cycle();
        reset = 1'b0;

        // Allocate on taken miss; same-cycle fetch still sees the empty entry
        bus.PCF = 32'h100;
        setE(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 32'h104);
        expectFetch("same_cycle_old", 1'b0, 32'h104);
        expectE("alloc", 1'b1, 32'h80);
        cycle();
        idleE();
        expectFetch("alloc_hit", 1'b1, 32'h80);
        expectCnt("after_alloc", 1, 1);
        cycle();

        // T,T,N,N training: WT->ST->ST->WT->WNT
        for (int i = 0; i < 4; i++) begin
            bus.PCF = 32'h100;
            setE(1'b1, 1'b1, 1'b0, outs[i], 32'h100, 32'h80, 32'h80);
            expectFetch($sformatf("train%0d_pred", i), 1'b1, 32'h80);
            expectE($sformatf("train%0d", i), miss[i], outs[i] ? 32'h80 : 32'h104);
            cycle();
        end
        idleE();
        expectFetch("ctr_wnt", 1'b0, 32'h104);
        expectCnt("after_train", 5, 3);
        cycle();

        // Retrain to taken, then alias from a different tag at the same index
        bus.PCF = 32'h200;
        setE(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 32'h104);
        expectFetch("alias_pre", 1'b0, 32'h204);
        expectE("retrain", 1'b1, 32'h80);
        cycle();
        idleE();
        bus.PCF = 32'h100;
        expectFetch("retrained", 1'b1, 32'h80);
        cycle();
        bus.PCF = 32'h200;
        expectFetch("alias", 1'b0, 32'h204);
        cycle();

        // Jump allocates strongly taken
        bus.PCF = 32'h340;
        setE(1'b1, 1'b0, 1'b1, 1'b1, 32'h340, 32'h500, 32'h344);
        expectFetch("jmp_pre", 1'b0, 32'h344);
        expectE("jmp", 1'b1, 32'h500);
        cycle();
        idleE();
        expectFetch("jmp_hit", 1'b1, 32'h500);
        expectCnt("after_jmp", 7, 5);
        cycle();

        // Non-branch hitting a stale entry: mispredict and invalidate
        setE(1'b1, 1'b0, 1'b0, 1'b0, 32'h340, 32'h0, 32'h500);
        expectFetch("stale_pre", 1'b1, 32'h500);
        expectE("stale", 1'b1, 32'h344);
        cycle();
        idleE();
        expectFetch("stale_gone", 1'b0, 32'h344);
        expectCnt("after_stale", 7, 6);
        cycle();

        // Bubble in E: no mispredict, no write
        bus.PCF = 32'h380;
        setE(1'b0, 1'b1, 1'b0, 1'b1, 32'h380, 32'h600, 32'h384);
        expectE("bubble", 1'b0, 32'h600);
        cycle();
        idleE();
        expectFetch("bubble_nowrite", 1'b0, 32'h384);
        expectCnt("after_bubble", 7, 6);
        cycle();

        // Not-taken miss: correct prediction, no allocation
        bus.PCF = 32'h3C0;
        setE(1'b1, 1'b1, 1'b0, 1'b0, 32'h3C0, 32'h700, 32'h3C4);
        expectE("nt_miss", 1'b0, 32'h3C4);
        cycle();
        idleE();
        expectFetch("nt_nowrite", 1'b0, 32'h3C4);
        expectCnt("after_nt", 8, 6);
        cycle();

        // Reset wins over a same-cycle taken update
        reset   = 1'b1;
        bus.PCF = 32'h400;
        setE(1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h700, 32'h404);
        cycle();
        reset = 1'b0;
        idleE();
        expectFetch("rst_wins", 1'b0, 32'h404);
        expectCnt("rst_cnt", 0, 0);
        cycle();
        bus.PCF = 32'h100;
        expectFetch("rst_cleared", 1'b0, 32'h104);
        cycle();

        // Three mispredicts after reset
        for (int i = 0; i < 3; i++) begin
            pc = 32'h600 + 32'(i * 4);
            setE(1'b1, 1'b1, 1'b0, 1'b1, pc, 32'h800, pc + 32'd4);
            expectE($sformatf("post_rst%0d", i), 1'b1, 32'h800);
            cycle();
        end
        idleE();
        expectCnt("three_miss", 3, 3);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
